reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on and lock-driven reset generator for iCE40 designs. It holds a configurable number of reset channels asserted until an enable input, typically a PLL lock, has been stable for a programmable number of cycles. It then releases the channels one at a time, in index order, with a fixed gap between releases. Any loss of enable or any software reset request re-asserts every channel and restarts the sequence. It sits at the top level, between the clock source and the per-subsystem reset nets.

## Interface

- NUM_CH, default 4: number of reset channels; must be at least 1.
- COUNT, default 100: cycles `en` must be continuously high before channel 0 releases; must be at least 2.
- STAGE_GAP, default 16: cycles between successive channel releases; must be at least 1.
- POLARITY, default all ones: NUM_CH-bit mask. Bit i = 1 makes `rst_out[i]` active-high; bit i = 0 makes it active-low.

- clk  input  1  single clock; all logic is on its rising edge.
- sreset  input  1  reset, synchronous, active-high; forces the sequencer to HOLD.
- en  input  1  enable/lock; low aborts and holds the sequence.
- soft_req  input  1  software reset request; level-sensitive, and high on any edge aborts.
- rst_out  output  NUM_CH  per-channel reset outputs, registered, polarity set per POLARITY.
- done  output  1  high when every channel has been released (state RUN).

## Operation

- Internal state:
  - state ∈ {HOLD, STAGE, RUN}, encoded with HOLD = 0.
  - `ctr`, width $clog2(max(COUNT, STAGE_GAP)+1).
  - `stage`, width $clog2(NUM_CH+1).
  - `released[NUM_CH-1:0]`.
- All registers initialise to 0, so configuration-time power-up equals the HOLD state.
- `rst_out[i]` is registered: `released[i] ? ~POLARITY[i] : POLARITY[i]`. `done` is registered.
- Priority on each edge, highest first:
  1. `sreset`
  2. abort (`en == 0` or `soft_req == 1`)
  3. normal progress
- `sreset`, and abort in any state, both do the following on that edge:
  - state <= HOLD
  - ctr <= 0, stage <= 0, released <= 0
  - all `rst_out` asserted, done <= 0
- HOLD:
  - If `en == 1` and `ctr != COUNT-1`: ctr <= ctr+1.
  - If `ctr == COUNT-1`: released[0] <= 1 and ctr <= 0.
    - NUM_CH == 1: state <= RUN and done <= 1 on the same edge.
    - Otherwise: state <= STAGE and stage <= 1.
- STAGE:
  - ctr increments each edge.
  - If `ctr == STAGE_GAP-1`: released[stage] <= 1, stage <= stage+1, ctr <= 0.
  - If stage == NUM_CH-1 at that edge: state <= RUN and done <= 1 on the same edge.
- RUN: holds until an abort or `sreset`. Counters are frozen.
- Releases are strictly ascending by channel index. Re-assertion is simultaneous on all channels.
- Once released, a channel is never re-asserted individually; only a full abort re-asserts it.

## Timing

- Let E1 be the first edge with `sreset = 0`, `en = 1`, `soft_req = 0`. The inputs stay the same on all following edges.
- Channel k deasserts on edge E(COUNT + k·STAGE_GAP), for k = 0…NUM_CH-1.
- `done` rises on the same edge as channel NUM_CH-1.
- Abort latency is 1 edge. The abort input is sampled on edge N, and every `rst_out` is asserted and `done` is low after edge N.
- A single-cycle low on `en` during HOLD clears `ctr`. The full COUNT must then elapse again from the next high edge.
- `soft_req` held high keeps the block in HOLD with ctr = 0. Counting starts on the first edge after it drops.
- Simultaneous `sreset` and abort give the same result.
- `en` rising on the same edge as `sreset` deasserting: that edge counts as E1.
- Reset mid-sequence (HOLD, STAGE or RUN) always restarts from channel 0 with the full COUNT.
- `ctr` never exceeds max(COUNT, STAGE_GAP)-1, so it has no wrap-around.

## Test plan

All scenarios use NUM_CH=3, COUNT=4, STAGE_GAP=2, POLARITY=3'b101.

- **Power-up:** `sreset` high for 2 cycles, `en` = 1 → while `sreset` is high, `rst_out` = 3'b101 and `done` = 0.
  - After `sreset` falls (first edge E1), `rst_out` = 3'b100 after E4, 3'b110 after E6, and 3'b010 after E8.
  - `done` rises after E8 and stays high for 50 further cycles.
- **Lock glitch in HOLD:** `en` high for 3 edges, low for 1, then high → no release until 4 edges after `en` returns.
- **Abort in STAGE:** `en` drops for 1 cycle at E5 (after ch0 released) → `rst_out` = 3'b101 and `done` = 0 after E5.
  - On return, the full schedule repeats relative to the new E1.
- **Soft request in RUN:** `soft_req` is a 1-cycle pulse while `done` = 1 → all channels asserted on the next edge and `done` = 0.
  - Release of ch0 follows 4 edges after the pulse.
- **Held `soft_req`:** `soft_req` high for 10 cycles with `en` = 1 → `rst_out` stays 3'b101 throughout.
  - Ch0 releases on the 4th edge after `soft_req` falls.
- **NUM_CH=1, COUNT=2:** `en` = 1 from E1 → `rst_out` deasserts and `done` rises together after E2.

Source files
------------

// File: rtl/reset_sequencer.sv
// Lock-driven reset sequencer: holds all channels in reset until `en` has been stable for
// COUNT cycles, then releases them in index order spaced STAGE_GAP cycles apart.
module reset_sequencer #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       COUNT     = 100,
  parameter int unsigned       STAGE_GAP = 16,
  parameter logic [NUM_CH-1:0] POLARITY  = '1
) (
  input  logic              clk,
  input  logic              sreset,
  input  logic              en,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              done
);

  localparam int unsigned CtrMax = (COUNT > STAGE_GAP) ? COUNT : STAGE_GAP;
  localparam int unsigned CtrW   = $clog2(CtrMax + 1);
  localparam int unsigned StageW = $clog2(NUM_CH + 1);

  localparam logic [CtrW-1:0]   CountLast = CtrW'(COUNT - 1);
  localparam logic [CtrW-1:0]   GapLast   = CtrW'(STAGE_GAP - 1);
  localparam logic [StageW-1:0] StageLast = StageW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StStage = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CtrW-1:0]     ctr_q;
  logic [StageW-1:0]   stage_q;
  logic [NUM_CH-1:0]   released_q;

  always_ff @(posedge clk) begin
    if (sreset || !en || soft_req) begin
      state_q    <= StHold;
      ctr_q      <= '0;
      stage_q    <= '0;
      released_q <= '0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (ctr_q == CountLast) begin
            released_q[0] <= 1'b1;
            ctr_q         <= '0;
            if (NUM_CH == 1) begin
              state_q <= StRun;
              done    <= 1'b1;
            end else begin
              state_q <= StStage;
              stage_q <= StageW'(1);
            end
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        StStage: begin
          if (ctr_q == GapLast) begin
            ctr_q   <= '0;
            stage_q <= stage_q + 1'b1;
            for (int unsigned i = 1; i < NUM_CH; i++) begin
              if (stage_q == StageW'(i)) released_q[i] <= 1'b1;
            end
            if (stage_q == StageLast) begin
              state_q <= StRun;
              done    <= 1'b1;
            end
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        StRun: ;
        default: state_q <= StHold;
      endcase
    end
  end

  // XOR with a constant is pure wiring/inversion, so rst_out is still a flop output, and an
  // all-zero power-up released_q already presents the asserted (HOLD) levels.
  assign rst_out = released_q ^ POLARITY;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random en/soft_req/sreset traffic, checked
// against a model that tracks only the number of consecutive good edges since the last abort.
module tb_reset_sequencer;

  localparam logic [2:0] P3 = 3'b101;

  logic       clk = 1'b0;
  logic       sreset = 1'b1;
  logic       en = 1'b0;
  logic       soft_req = 1'b0;
  logic [2:0] rst3;
  logic       done3;
  logic [0:0] rst1;
  logic       done1;

  int tests = 0;
  int fails = 0;
  int n     = 0;  // consecutive edges with sreset=0, en=1, soft_req=0

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH   (3),
    .COUNT    (4),
    .STAGE_GAP(2),
    .POLARITY (3'b101)
  ) u_dut3 (
    .clk     (clk),
    .sreset  (sreset),
    .en      (en),
    .soft_req(soft_req),
    .rst_out (rst3),
    .done    (done3)
  );

  reset_sequencer #(
    .NUM_CH(1),
    .COUNT (2)
  ) u_dut1 (
    .clk     (clk),
    .sreset  (sreset),
    .en      (en),
    .soft_req(soft_req),
    .rst_out (rst1),
    .done    (done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h (n=%0d)", tag, $time, obs, exp, n);
    end
  endtask

  // Channel k is released once n reaches COUNT + k*STAGE_GAP.
  function automatic logic [2:0] exp_rst3(input int cnt);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = (cnt >= 4 + 2 * k) ? ~P3[k] : P3[k];
    return r;
  endfunction

  task automatic step(input logic sr, input logic e, input logic s);
    sreset   = sr;
    en       = e;
    soft_req = s;
    @(posedge clk);
    if (sr || !e || s) n = 0;
    else if (n < 1000) n++;
    #1;
    check("rst3", {29'd0, rst3}, {29'd0, exp_rst3(n)});
    check("done3", {31'd0, done3}, {31'd0, n >= 8});
    check("rst1", {31'd0, rst1}, {31'd0, n < 2});
    check("done1", {31'd0, done1}, {31'd0, n >= 2});
  endtask

  task automatic run(input int cycles, input logic sr, input logic e, input logic s);
    for (int i = 0; i < cycles; i++) step(sr, e, s);
  endtask

  initial begin
    // Power-up, then full schedule and 50 cycles in RUN
    run(2, 1'b1, 1'b1, 1'b0);
    run(58, 1'b0, 1'b1, 1'b0);

    // Lock glitch while still in HOLD
    step(1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run(12, 1'b0, 1'b1, 1'b0);

    // Abort in STAGE after ch0 has released
    step(1'b1, 1'b1, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run(12, 1'b0, 1'b1, 1'b0);

    // One-cycle soft request while in RUN
    step(1'b0, 1'b1, 1'b1);
    run(12, 1'b0, 1'b1, 1'b0);

    // Held soft request
    run(10, 1'b0, 1'b1, 1'b1);
    run(12, 1'b0, 1'b1, 1'b0);

    // Simultaneous sreset and abort
    step(1'b1, 1'b0, 1'b1);
    run(10, 1'b0, 1'b1, 1'b0);

    // Random traffic, biased towards long good stretches
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
